rx_packet_writer: RTL

- Sits directly upstream of the RX packet buffer. Takes the byte stream from the 1G RX MAC, one byte per cycle.
- Packs bytes into buffer-width words and drives the buffer's write-side port (word writes, size, slot reserve).
- Commits only packets that are clean and fit in a slot. Errored, oversize or no-slot packets are dropped, and a status pulse is raised.

---
 rtl/rx_packet_writer_if.sv | 34 +++
 rtl/rx_packet_writer.sv | 111 +++++++++++
 2 files changed

// File: rtl/rx_packet_writer_if.sv
// rtl/rx_packet_writer_if.sv - MAC byte stream and buffer write-side signals for rx_packet_writer
interface rx_packet_writer_if #(
  parameter int data_width_p = 64
);
  logic                    rx_v_i;
  logic [7:0]              rx_data_i;
  logic                    rx_last_i;
  logic                    rx_error_i;
  logic                    rx_ready_and_o;
  logic                    write_slot_v_o;
  logic                    write_slot_ready_and_i;
  logic                    write_size_v_o;
  logic [15:0]             write_size_o;
  logic                    write_v_o;
  logic [10:0]             write_addr_o;
  logic [data_width_p-1:0] write_data_o;
  logic [1:0]              write_op_size_o;
  logic                    packet_done_o;
  logic                    packet_dropped_o;

  modport slave (
    input  rx_v_i, rx_data_i, rx_last_i, rx_error_i, write_slot_ready_and_i,
    output rx_ready_and_o, write_slot_v_o, write_size_v_o, write_size_o,
           write_v_o, write_addr_o, write_data_o, write_op_size_o,
           packet_done_o, packet_dropped_o
  );

  modport master (
    output rx_v_i, rx_data_i, rx_last_i, rx_error_i, write_slot_ready_and_i,
    input  rx_ready_and_o, write_slot_v_o, write_size_v_o, write_size_o,
           write_v_o, write_addr_o, write_data_o, write_op_size_o,
           packet_done_o, packet_dropped_o
  );
endinterface

// File: rtl/rx_packet_writer.sv
// rtl/rx_packet_writer.sv - packs RX MAC bytes into buffer words and commits clean packets to a slot
module rx_packet_writer #(
  parameter int data_width_p = 64,
  parameter int max_bytes_p  = 2048
) (
  input logic           clk_i,
  input logic           reset_i,
  rx_packet_writer_if.slave bus
);
  localparam int bytes_lp     = data_width_p / 8;
  localparam int lane_bits_lp = $clog2(bytes_lp);

  typedef enum logic [1:0] {IDLE, RECV, COMMIT, DROP} state_e;
  state_e state_r, state_n;

  logic [11:0]             count_r;
  logic [data_width_p-1:0] word_r, pend_data_r, merged;
  logic [10:0]             pend_addr_r, byte_idx, word_addr;
  logic                    pend_r, dropped_r;
  logic                    ready, accept, store, drop_pulse, flush;
  logic [lane_bits_lp-1:0] lane;

  assign accept    = bus.rx_v_i & ready;
  // A packet start always lands in lane 0, whatever count was left behind.
  assign byte_idx  = (state_r == IDLE) ? 11'd0 : count_r[10:0];
  assign lane      = byte_idx[lane_bits_lp-1:0];
  assign word_addr = byte_idx & ~11'(bytes_lp - 1);
  assign flush     = store & ((lane == lane_bits_lp'(bytes_lp - 1)) | bus.rx_last_i);

  always_comb begin
    merged = word_r;
    merged[8*lane +: 8] = bus.rx_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) state_r <= IDLE;
    else         state_r <= state_n;
  end

  always_comb begin
    state_n    = state_r;
    ready      = 1'b1;
    store      = 1'b0;
    drop_pulse = 1'b0;
    case (state_r)
      IDLE: if (accept) begin
        if (!bus.write_slot_ready_and_i || bus.rx_error_i) begin
          if (bus.rx_last_i) drop_pulse = 1'b1;
          else               state_n    = DROP;
        end else begin
          store   = 1'b1;
          state_n = bus.rx_last_i ? COMMIT : RECV;
        end
      end
      RECV: if (accept) begin
        if (bus.rx_error_i || count_r == 12'(max_bytes_p)) begin
          drop_pulse = bus.rx_last_i;
          state_n    = bus.rx_last_i ? IDLE : DROP;
        end else begin
          store = 1'b1;
          if (bus.rx_last_i) state_n = COMMIT;
        end
      end
      COMMIT: begin
        ready   = 1'b0;
        state_n = IDLE;
      end
      DROP: if (accept && bus.rx_last_i) begin
        drop_pulse = 1'b1;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_r     <= 12'd0;
      word_r      <= '0;
      pend_r      <= 1'b0;
      pend_addr_r <= 11'd0;
      pend_data_r <= '0;
      dropped_r   <= 1'b0;
    end else begin
      // Only a flush from a stored byte schedules a write, so a drop cancels it.
      pend_r    <= flush;
      dropped_r <= drop_pulse;
      if (flush) begin
        pend_data_r <= merged;
        pend_addr_r <= word_addr;
      end
      if (store) begin
        count_r <= (state_r == IDLE) ? 12'd1 : count_r + 12'd1;
        word_r  <= flush ? '0 : merged;
      end else if (accept) begin
        word_r <= '0;
      end
    end
  end

  assign bus.rx_ready_and_o   = ready;
  assign bus.write_slot_v_o   = (state_r == COMMIT);
  assign bus.write_size_v_o   = (state_r == COMMIT);
  assign bus.write_size_o     = (state_r == COMMIT) ? {4'd0, count_r} : 16'd0;
  assign bus.write_v_o        = pend_r;
  assign bus.write_addr_o     = pend_addr_r;
  assign bus.write_data_o     = pend_data_r;
  assign bus.write_op_size_o  = (data_width_p == 64) ? 2'b11 : 2'b10;
  assign bus.packet_done_o    = (state_r == COMMIT);
  assign bus.packet_dropped_o = dropped_r;
endmodule
